// File: rtl/fifo_pkg.sv
// Shared fifo defaults and write-arbiter state encoding.
// Used by the fifo and by every block driving its write port.
package fifo_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int DEPTH       = 16;
    localparam int ADDRESS_BUS = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
// Finds the first set request searching upward from ptr, with wrap.
module rr_pick #(
    parameter int n  = 4,
    parameter int iw = 2
) (
    input  logic [n-1:0]  req,
    input  logic [iw-1:0] ptr,
    output logic [n-1:0]  onehot,
    output logic [iw-1:0] idx,
    output logic          any
);

    logic [iw-1:0] j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = '0;
        for (int k = 0; k < n; k++) begin
            j = iw'((int'(ptr) + k) % n);
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = j;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the fifo write port between producers.
// A grant locks the port for a burst of up to max_burst words.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int num_req    = 4,
    parameter int max_burst  = 4,
    parameter int cnt_w      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_req-1:0]            req,
    input  logic [num_req*data_width-1:0] req_data,
    output logic [num_req-1:0]            ack,
    output logic [num_req-1:0]            grant,
    input  logic                          fifo_full,
    output logic                          fifo_we,
    output logic [data_width-1:0]         fifo_datain,
    output logic                          busy
);

    localparam int iw = (num_req > 1) ? $clog2(num_req) : 1;
    localparam logic [iw-1:0]    last_idx = iw'(num_req - 1);
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(max_burst - 1);

    logic [0:0]         state;
    logic [iw-1:0]      owner;
    logic [iw-1:0]      rr_ptr;
    logic [cnt_w-1:0]   burst_cnt;
    logic [num_req-1:0] pick_oh;
    logic [iw-1:0]      pick_idx;
    logic               pick_any;
    logic               own_req;
    logic               accept;
    logic               release_now;

    rr_pick #(
        .n  (num_req),
        .iw (iw)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign own_req = req[owner];
    assign accept  = (state == OWN) && own_req && !fifo_full;
    assign busy    = (state == OWN);
    assign fifo_we = accept;

    // A missing request ends the burst with no transfer.
    assign release_now = !own_req
                      || (accept && (burst_cnt == last_cnt));

    always_comb begin
        ack        = '0;
        ack[owner] = accept;
    end

    always_comb begin
        fifo_datain = '0;
        if (state == OWN)
            fifo_datain = req_data[owner*data_width +: data_width];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= OWN;
                        owner     <= pick_idx;
                        grant     <= pick_oh;
                        burst_cnt <= '0;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        state  <= IDLE;
                        grant  <= '0;
                        rr_ptr <= (owner == last_idx) ? '0 : owner + 1'b1;
                    end else if (accept) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter.
// Directed table, corner sequences and random stress against a model.
module tb_fifo_wr_arbiter;
    import fifo_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]   ack;
    logic [NR-1:0]   grant;
    logic            fifo_full = 1'b0;
    logic            fifo_we;
    logic [DW-1:0]   fifo_datain;
    logic            busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .data_width (DW),
        .num_req    (NR),
        .max_burst  (MB),
        .cnt_w      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .grant       (grant),
        .fifo_full   (fifo_full),
        .fifo_we     (fifo_we),
        .fifo_datain (fifo_datain),
        .busy        (busy)
    );

    typedef struct {
        logic [3:0] r;
        bit         f;
        logic [3:0] a;
        bit         we;
        logic [3:0] g;
        bit         b;
        logic [7:0] d;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // fifo contents as seen by the bench, plus arbiter model state
    byte unsigned fq[$];
    int  m_own, m_cnt, m_ptr;
    bit  e_acc;

    logic [NR-1:0] s_req, s_ack;
    logic          s_we, s_busy;
    logic [DW-1:0] s_din;

    int acks_seen, writes_seen, max_wait;
    int wait_cnt[NR];
    int gq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_own = -1;
        m_cnt = 0;
        m_ptr = 0;
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
        gq.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive(input logic [NR-1:0] r,
                         input logic [NR*DW-1:0] d, input bit xf);
        req       = r;
        req_data  = d;
        fifo_full = (fq.size() >= DEPTH) || xf;
        #3;
    endtask

    task automatic mcheck(input string tag);
        logic [NR-1:0] eg, ea;
        logic [DW-1:0] ed;
        eg    = '0;
        ea    = '0;
        ed    = '0;
        e_acc = 1'b0;
        if (m_own >= 0) begin
            eg[m_own] = 1'b1;
            ed        = req_data[m_own*DW +: DW];
            e_acc     = req[m_own] && !fifo_full;
            if (e_acc) ea[m_own] = 1'b1;
        end
        chk({tag, " grant"}, grant, eg);
        chk({tag, " ack"}, ack, ea);
        chk({tag, " we"}, fifo_we, e_acc);
        chk({tag, " busy"}, busy, m_own >= 0);
        chk({tag, " din"}, fifo_datain, ed);
        s_req  = req;
        s_ack  = ack;
        s_we   = fifo_we;
        s_busy = busy;
        s_din  = fifo_datain;
    endtask

    task automatic tick(input bit rd);
        bit found;
        int j;
        @(posedge clk);
        if (s_we) begin
            fq.push_back(s_din);
            writes_seen++;
        end
        acks_seen += $countones(s_ack);
        if (rd && fq.size() > 0) void'(fq.pop_front());
        if (m_own < 0) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                j = (m_ptr + k) % NR;
                if (!found && s_req[j]) begin
                    found = 1'b1;
                    m_own = j;
                    m_cnt = 0;
                end
            end
        end else if (!s_req[m_own]) begin
            m_ptr = (m_own + 1) % NR;
            m_own = -1;
        end else if (e_acc) begin
            m_cnt++;
            if (m_cnt == MB) begin
                m_ptr = (m_own + 1) % NR;
                m_own = -1;
            end
        end
        #1;
        // fairness bookkeeping on every new grant seen on the DUT
        if (!s_busy && grant != '0) begin
            for (int i = 0; i < NR; i++) begin
                if (grant[i]) begin
                    gq.push_back(i);
                    wait_cnt[i] = 0;
                end else if (s_req[i]) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end else begin
                    wait_cnt[i] = 0;
                end
            end
        end
    endtask

    task automatic cyc(input logic [NR-1:0] r, input logic [NR*DW-1:0] d,
                       input bit xf, input bit rd, input string tag);
        drive(r, d, xf);
        mcheck(tag);
        tick(rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tv[15];
        logic [NR*DW-1:0] dd;
        logic [DW-1:0] st;
        int w;

        dd = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tv[0]  = '{4'b0010, 0, 4'b0000, 0, 4'b0000, 0, 8'h00};
        tv[1]  = '{4'b0010, 0, 4'b0010, 1, 4'b0010, 1, 8'hA1};
        tv[2]  = '{4'b0010, 1, 4'b0000, 0, 4'b0010, 1, 8'hA1};
        tv[3]  = '{4'b0010, 0, 4'b0010, 1, 4'b0010, 1, 8'hA1};
        tv[4]  = '{4'b0001, 0, 4'b0000, 0, 4'b0010, 1, 8'hA1};
        tv[5]  = '{4'b0011, 0, 4'b0000, 0, 4'b0000, 0, 8'h00};
        tv[6]  = '{4'b0011, 0, 4'b0001, 1, 4'b0001, 1, 8'hA0};
        tv[7]  = '{4'b0011, 0, 4'b0001, 1, 4'b0001, 1, 8'hA0};
        tv[8]  = '{4'b0011, 0, 4'b0001, 1, 4'b0001, 1, 8'hA0};
        tv[9]  = '{4'b0011, 0, 4'b0001, 1, 4'b0001, 1, 8'hA0};
        tv[10] = '{4'b0011, 0, 4'b0000, 0, 4'b0000, 0, 8'h00};
        tv[11] = '{4'b0000, 0, 4'b0000, 0, 4'b0010, 1, 8'hA1};
        tv[12] = '{4'b1001, 0, 4'b0000, 0, 4'b0000, 0, 8'h00};
        tv[13] = '{4'b1001, 1, 4'b0000, 0, 4'b1000, 1, 8'hA3};
        tv[14] = '{4'b1001, 0, 4'b1000, 1, 4'b1000, 1, 8'hA3};

        acks_seen   = 0;
        writes_seen = 0;
        max_wait    = 0;
        model_reset();

        // reset state
        do_reset();
        drive('0, dd, 0);
        mcheck("reset");
        tick(0);

        // directed table
        do_reset();
        fq.delete();
        for (int i = 0; i < 15; i++) begin
            drive(tv[i].r, dd, tv[i].f);
            mcheck("tvm");
            chk($sformatf("tv%0d ack", i), ack, tv[i].a);
            chk($sformatf("tv%0d we", i), fifo_we, tv[i].we);
            chk($sformatf("tv%0d grant", i), grant, tv[i].g);
            chk($sformatf("tv%0d busy", i), busy, tv[i].b);
            chk($sformatf("tv%0d din", i), fifo_datain, tv[i].d);
            tick(0);
        end

        // single requester streaming 0..4
        do_reset();
        fq.delete();
        w = 0;
        for (int c = 0; c < 20 && w < 5; c++) begin
            drive(4'b0001, {24'h0, 8'(w)}, 0);
            mcheck("t1");
            if (ack[0]) w++;
            tick(0);
        end
        chk("t1 words", fq.size(), 5);
        for (int i = 0; i < 5 && i < fq.size(); i++)
            chk($sformatf("t1 word%0d", i), fq[i], i);
        cyc('0, '0, 0, 0, "t1 idle");

        // all requesters streaming until the fifo fills
        do_reset();
        fq.delete();
        for (int c = 0; c < 60 && fq.size() < DEPTH; c++)
            cyc(4'b1111, {8'h03, 8'h02, 8'h01, 8'h00}, 0, 0, "t2");
        chk("t2 fill", fq.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < fq.size(); i++)
            chk($sformatf("t2 word%0d", i), fq[i], i / 4);
        for (int c = 0; c < 3; c++)
            cyc(4'b1111, {8'h03, 8'h02, 8'h01, 8'h00}, 0, 0, "t2 full");
        chk("t2 ngrant", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++)
            chk($sformatf("t2 order%0d", i), gq[i], i % NR);

        // stall on full, resume after one read
        do_reset();
        fq.delete();
        for (int i = 0; i < DEPTH - 1; i++) fq.push_back(8'hEE);
        cyc(4'b0100, dd, 0, 0, "t3 arb");
        cyc(4'b0100, dd, 0, 0, "t3 wr");
        drive(4'b0100, dd, 0);
        mcheck("t3 stall");
        chk("t3 stall we", fifo_we, 0);
        st = fifo_datain;
        tick(1);
        drive(4'b0100, dd, 0);
        mcheck("t3 resume");
        chk("t3 resume ack", ack, 4'b0100);
        chk("t3 resume din", fifo_datain, st);
        tick(0);

        // reset in the middle of a burst
        do_reset();
        fq.delete();
        cyc(4'b0001, dd, 0, 0, "t5 arb");
        cyc(4'b0001, dd, 0, 0, "t5 w0");
        cyc(4'b0001, dd, 0, 0, "t5 w1");
        rst = 1'b1;
        req = 4'b1000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive(4'b1000, dd, 0);
        mcheck("t5 post");
        chk("t5 busy", busy, 0);
        tick(0);
        drive(4'b1000, dd, 0);
        mcheck("t5 regrant");
        chk("t5 grant", grant, 4'b1000);
        tick(0);

        // random stress
        do_reset();
        fq.delete();
        acks_seen   = 0;
        writes_seen = 0;
        max_wait    = 0;
        for (int c = 0; c < 1000; c++) begin
            drive(4'($urandom_range(0, 15)), {$urandom}, $urandom_range(0, 3) == 0);
            mcheck("rnd");
            chk("rnd we&full", fifo_we & fifo_full, 0);
            chk("rnd ack1hot", $onehot0(ack), 1);
            tick($urandom_range(0, 1) == 1);
        end
        chk("rnd ack=wr", acks_seen, writes_seen);
        chk("rnd fairness", max_wait < NR, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
